// File: rtl/oddr_pattern_pkg.sv
// Shared types and constants for the multi-lane DDR pattern generator.
package oddr_pattern_pkg;

    typedef enum logic [1:0] {
        COUNT  = 2'd0,
        PRBS7  = 2'd1,
        WALK1  = 2'd2,
        CLKFWD = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic [6:0] PRBS7_SEED  = 7'h7F;
    localparam int         PRBS7_TAP_A = 6;
    localparam int         PRBS7_TAP_B = 5;

    // One step of x^7+x^6+1: shift left, feedback enters at bit 0.
    function automatic logic [6:0] prbs7_step(input logic [6:0] s);
        return {s[5:0], s[PRBS7_TAP_A] ^ s[PRBS7_TAP_B]};
    endfunction

endpackage

// File: rtl/oddr_pattern_gen_if.sv
// Control/status bundle between a bring-up controller and oddr_pattern_gen.
interface oddr_pattern_gen_if #(
    parameter int NUM_CH  = 4,
    parameter int BURST_W = 16
);
    import oddr_pattern_pkg::*;

    // start is a request accepted only while the generator sits in IDLE (busy=0);
    // each accepted start yields exactly one done pulse unless reset intervenes.
    logic               start;
    logic               stop;
    logic [1:0]         mode;
    logic [BURST_W-1:0] burst_len;
    logic [NUM_CH-1:0]  ch_en;
    logic               busy;
    logic               done;
    state_e             dbg_state;

    modport master (
        output start, stop, mode, burst_len, ch_en,
        input  busy, done, dbg_state
    );

    modport slave (
        input  start, stop, mode, burst_len, ch_en,
        output busy, done, dbg_state
    );

endinterface

// File: rtl/oddr_lane.sv
// One DDR pad lane: ODDRE1-equivalent same-edge DDR register, matched T register, IOBUF.
module oddr_lane #(
    parameter SIM_DEVICE = "ULTRASCALE_PLUS"
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d1,
    input  logic d2,
    input  logic oe,
    inout  wire  pad_io,
    output logic pad_rx
);

    if (SIM_DEVICE != "ULTRASCALE_PLUS" && SIM_DEVICE != "ULTRASCALE") begin : g_bad_device
        $error("oddr_lane: unsupported SIM_DEVICE");
    end

    logic d1_q, d1_d;
    logic d2_q, d2_d;
    logic t_q, t_d;
    logic oq;

    always_comb begin
        d1_d = d1;
        d2_d = d2;
        t_d  = ~oe;
    end

    // SR tied to ~rst_n: Q forced low and pad released asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d1_q <= 1'b0;
            d2_q <= 1'b0;
            t_q  <= 1'b1;
        end else begin
            d1_q <= d1_d;
            d2_q <= d2_d;
            t_q  <= t_d;
        end
    end

    // D1 occupies the high phase, D2 the low phase of the same cycle.
    assign oq     = clk ? d1_q : d2_q;
    assign pad_io = t_q ? 1'bz : oq;
    assign pad_rx = pad_io;

endmodule

// File: rtl/oddr_pattern_gen.sv
// Multi-lane DDR pattern generator: burst FSM, beat/pattern counters, PRBS7 and pattern mux.
module oddr_pattern_gen
    import oddr_pattern_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int BURST_W    = 16,
    parameter int CNT_W      = 8,
    parameter     SIM_DEVICE = "ULTRASCALE_PLUS"
) (
    input  logic                clk,
    input  logic                rst_n,
    oddr_pattern_gen_if.slave   ctl,
    inout  wire  [NUM_CH-1:0]   pad_io,
    output logic [NUM_CH-1:0]   pad_rx
);

    if (NUM_CH < 1 || NUM_CH > 8) begin : g_num_ch_chk
        $error("oddr_pattern_gen: NUM_CH must be 1..8");
    end
    if (CNT_W < 2 * NUM_CH) begin : g_cnt_w_chk
        $error("oddr_pattern_gen: CNT_W must be >= 2*NUM_CH");
    end

    localparam int                WALK_W    = $clog2(2 * NUM_CH);
    localparam logic [WALK_W-1:0] WALK_LAST = WALK_W'(2 * NUM_CH - 1);

    state_e             state_q, state_d;
    mode_e              mode_q, mode_d;
    logic [BURST_W-1:0] blen_q, blen_d;
    logic [NUM_CH-1:0]  ch_en_q, ch_en_d;
    logic [BURST_W-1:0] beat_q, beat_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [6:0]         lfsr_q, lfsr_d;
    logic [WALK_W-1:0]  walk_q, walk_d;

    logic [6:0]         prbs_s1, prbs_s2;
    logic               busy;
    logic [NUM_CH-1:0]  d1, d2, oe;

    assign prbs_s1 = prbs7_step(lfsr_q);
    assign prbs_s2 = prbs7_step(prbs_s1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mode_q  <= COUNT;
            blen_q  <= '0;
            ch_en_q <= '0;
            beat_q  <= '0;
            cnt_q   <= '0;
            lfsr_q  <= PRBS7_SEED;
            walk_q  <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            blen_q  <= blen_d;
            ch_en_q <= ch_en_d;
            beat_q  <= beat_d;
            cnt_q   <= cnt_d;
            lfsr_q  <= lfsr_d;
            walk_q  <= walk_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        blen_d  = blen_q;
        ch_en_d = ch_en_q;
        beat_d  = beat_q;
        cnt_d   = cnt_q;
        lfsr_d  = lfsr_q;
        walk_d  = walk_q;
        case (state_q)
            IDLE: begin
                if (ctl.start) begin
                    state_d = ARM;
                    mode_d  = mode_e'(ctl.mode);
                    blen_d  = ctl.burst_len;
                    ch_en_d = ctl.ch_en;
                    beat_d  = '0;
                    cnt_d   = '0;
                    lfsr_d  = PRBS7_SEED;
                    walk_d  = '0;
                end
            end
            ARM: begin
                state_d = ctl.stop ? DONE : RUN;
            end
            RUN: begin
                beat_d = beat_q + BURST_W'(1);
                cnt_d  = cnt_q + CNT_W'(1);
                lfsr_d = prbs_s2;
                walk_d = (walk_q == WALK_LAST) ? '0 : walk_q + WALK_W'(1);
                // Current beat is always emitted; the exit takes effect next cycle.
                if (ctl.stop || (blen_q != '0 && beat_q == blen_q - BURST_W'(1))) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy = (state_q == ARM) || (state_q == RUN);

    always_comb begin
        d1 = '0;
        d2 = '0;
        if (state_q == RUN) begin
            case (mode_q)
                COUNT: begin
                    for (int c = 0; c < NUM_CH; c++) begin
                        d1[c] = cnt_q[2*c];
                        d2[c] = cnt_q[2*c+1];
                    end
                end
                PRBS7: begin
                    d1 = {NUM_CH{prbs_s1[0]}};
                    d2 = {NUM_CH{prbs_s2[0]}};
                end
                WALK1: begin
                    for (int c = 0; c < NUM_CH; c++) begin
                        d1[c] = (walk_q == WALK_W'(2*c));
                        d2[c] = (walk_q == WALK_W'(2*c+1));
                    end
                end
                CLKFWD: begin
                    d1 = '1;
                    d2 = '0;
                end
                default: begin
                    d1 = '0;
                    d2 = '0;
                end
            endcase
        end
    end

    assign oe = ch_en_q & {NUM_CH{busy}};

    assign ctl.busy      = busy;
    assign ctl.done      = (state_q == DONE);
    assign ctl.dbg_state = state_q;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
        oddr_lane #(
            .SIM_DEVICE(SIM_DEVICE)
        ) u_lane (
            .clk    (clk),
            .rst_n  (rst_n),
            .d1     (d1[c]),
            .d2     (d2[c]),
            .oe     (oe[c]),
            .pad_io (pad_io[c]),
            .pad_rx (pad_rx[c])
        );
    end

endmodule
